dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have the port memread_xm, input, 1 bit: the EX/MEM instruction is a load.
REQ-004 SHALL have the port memwrite_xm, input, 1 bit: the EX/MEM instruction is a store (st or stu).
REQ-005 SHALL have the port addr_xm, input, 16 bits: ALU-computed effective address.
REQ-006 SHALL have the port wdata_xm, input, 16 bits: store data.
REQ-007 SHALL have the port mem_busy, input, 1 bit: the memory cannot accept a request this cycle.
REQ-008 SHALL have the port mem_done, input, 1 bit: single-cycle pulse; the outstanding access has completed.
REQ-009 SHALL have the port mem_rdata, input, 16 bits: read data, valid when mem_done=1.
REQ-010 SHALL have the port mem_en, output, 1 bit: request strobe to memory.
REQ-011 SHALL have the port mem_wr, output, 1 bit: 1=write, 0=read; meaningful only while mem_en=1.
REQ-012 SHALL have the port mem_addr, output, 16 bits: registered request address.
REQ-013 SHALL have the port mem_wdata, output, 16 bits: registered request write data.
REQ-014 SHALL have the port stall_mem, output, 1 bit: freezes the PC and all pipeline registers up to and including EX/MEM.
REQ-015 SHALL have the port rdata_mw, output, 16 bits: load result toward MEM/WB.
REQ-016 SHALL have the port rdata_valid, output, 1 bit: rdata_mw is valid this cycle.
REQ-017 SHALL have the port err_mem, output, 1 bit: single-cycle pulse; access fault.

Function
REQ-018 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, DONE.
REQ-019 In IDLE, when exactly one of memread_xm/memwrite_xm is 1, SHALL: capture addr_xm, wdata_xm and memwrite_xm into mem_addr, mem_wdata and mem_wr; assert stall_mem combinationally in the same cycle; go to ISSUE.
REQ-020 In IDLE, when memread_xm and memwrite_xm are both 1, SHALL pulse err_mem for one cycle, start no access, leave stall_mem=0, and remain in IDLE.
REQ-021 In ISSUE, SHALL drive mem_en=1 and stall_mem=1.
REQ-022 The request SHALL be accepted when mem_en=1 and mem_busy=0; on acceptance go to WAIT.
REQ-023 While mem_busy=1, SHALL hold ISSUE with mem_en and all request fields stable.
REQ-024 In WAIT, SHALL drive mem_en=0 and stall_mem=1.
REQ-025 On mem_done=1 in WAIT, SHALL register mem_rdata into rdata_mw (reads only) and go to DONE.
REQ-026 mem_done received outside WAIT SHALL be ignored.
REQ-027 A 4-bit timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle without mem_done.
REQ-028 When the timeout counter reaches 15 with no mem_done, SHALL pulse err_mem, set rdata_mw=16'h0000, and go to DONE.
REQ-029 In DONE, SHALL drive stall_mem=0 and drive rdata_valid=1 if the access was a read; the pipeline advances at the end of that cycle.
REQ-030 DONE SHALL always go to IDLE; requests presented during DONE SHALL NOT be captured.
REQ-031 Back-to-back memory instructions SHALL therefore cost at least four cycles each: one IDLE-capture cycle, ISSUE, WAIT, DONE.
REQ-032 rdata_mw SHALL hold its value until the next read completes.

Reset
REQ-033 On rst_n=0, asynchronously and regardless of state, SHALL force: FSM=IDLE; mem_en=0; mem_wr=0; mem_addr=0; mem_wdata=0; stall_mem=0; rdata_mw=0; rdata_valid=0; err_mem=0; timeout counter=0.
REQ-034 Reset asserted mid-access SHALL abandon the access; a late mem_done arriving after reset SHALL be ignored.

Configuration
REQ-035 With DMEM_ALIGN_CHK_EN defined, a request in IDLE with addr_xm[0]=1 SHALL pulse err_mem, start no access, leave stall_mem=0, and remain in IDLE.
REQ-036 Without DMEM_ALIGN_CHK_EN, addr_xm[0] SHALL be ignored and odd addresses SHALL be issued unchanged.

Verification
REQ-037 Directed scenario, read: memread_xm=1, addr_xm=16'h0010; mem_busy=0; mem_done two cycles after acceptance with mem_rdata=16'hBEEF. Required: mem_en high one cycle; stall_mem high until DONE; rdata_mw=16'hBEEF with rdata_valid=1 in DONE.
REQ-038 Directed scenario, write under busy: memwrite_xm=1, addr_xm=16'h0020, wdata_xm=16'h1234; mem_busy=1 for 3 cycles. Required: mem_en, mem_wr=1, mem_addr=16'h0020 and mem_wdata=16'h1234 held for 4 cycles; rdata_valid never asserted.
REQ-039 Directed scenario, timeout: read issued, mem_done never asserted. Required: err_mem pulse 15 WAIT cycles after acceptance, then DONE with rdata_mw=16'h0000, then IDLE.
REQ-040 Directed scenario, conflict: memread_xm=1 and memwrite_xm=1 together. Required: err_mem pulse, mem_en stays 0, stall_mem stays 0.
REQ-041 Directed scenario, reset mid-access: rst_n driven low during WAIT, and a later mem_done pulse. Required: all outputs 0 immediately; the mem_done is ignored.
REQ-042 Directed scenario, alignment: addr_xm=16'h0011 with a read. Required with DMEM_ALIGN_CHK_EN: err_mem and no access. Required without it: normal access to 16'h0011.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: captures an EX/MEM load/store and runs the
// IDLE/ISSUE/WAIT/DONE memory handshake. The DMEM_ALIGN_CHK_EN macro enables rejection of odd addresses.
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memread_xm,
  input  logic        memwrite_xm,
  input  logic [15:0] addr_xm,
  input  logic [15:0] wdata_xm,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        stall_mem,
  output logic [15:0] rdata_mw,
  output logic        rdata_valid,
  output logic        err_mem
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] TMO_LAST = 4'd15;

  state_t      state_reg, state_next;
  logic [3:0]  tmo_reg, tmo_next, tmo_inc;
  logic        err_reg, err_next;
  logic [15:0] rdata_reg, rdata_next;
  logic [15:0] addr_reg, wdata_reg;
  logic        wr_reg;
  logic        capture;
  logic        one_req, both_req, misalign, req_ok, req_bad;
  logic        mem_en_c, stall_c;

  assign one_req  = memread_xm ^ memwrite_xm;
  assign both_req = memread_xm & memwrite_xm;

`ifdef DMEM_ALIGN_CHK_EN
  assign misalign = one_req & addr_xm[0];
`else
  assign misalign = 1'b0;
`endif

  assign req_ok  = one_req & ~misalign;
  assign req_bad = both_req | misalign;
  assign tmo_inc = tmo_reg + 4'd1;

  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    err_next   = 1'b0;
    rdata_next = rdata_reg;
    capture    = 1'b0;
    mem_en_c   = 1'b0;
    stall_c    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_ok) begin
          capture    = 1'b1;
          stall_c    = 1'b1;
          state_next = S_ISSUE;
        end else if (req_bad) begin
          err_next = 1'b1;
        end
      end
      S_ISSUE: begin
        mem_en_c = 1'b1;
        stall_c  = 1'b1;
        if (!mem_busy) begin
          tmo_next   = 4'd0;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (mem_done) begin
          if (!wr_reg) rdata_next = mem_rdata;
          state_next = S_DONE;
        end else if (tmo_inc == TMO_LAST) begin
          // Fifteenth silent WAIT cycle: give up and report a fault.
          tmo_next   = tmo_inc;
          err_next   = 1'b1;
          rdata_next = 16'h0000;
          state_next = S_DONE;
        end else begin
          tmo_next = tmo_inc;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      tmo_reg   <= 4'd0;
      err_reg   <= 1'b0;
      rdata_reg <= 16'h0000;
      addr_reg  <= 16'h0000;
      wdata_reg <= 16'h0000;
      wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      err_reg   <= err_next;
      rdata_reg <= rdata_next;
      if (capture) begin
        addr_reg  <= addr_xm;
        wdata_reg <= wdata_xm;
        wr_reg    <= memwrite_xm;
      end
    end
  end

  assign mem_en      = mem_en_c;
  assign stall_mem   = stall_c;
  assign mem_wr      = wr_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign rdata_mw    = rdata_reg;
  assign rdata_valid = (state_reg == S_DONE) & ~wr_reg;
  assign err_mem     = err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a table of whole transactions plus hand-written
// sequences for reset mid-access, stray mem_done and requests held through DONE.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread_xm, memwrite_xm;
  logic [15:0] addr_xm, wdata_xm;
  logic        mem_busy, mem_done;
  logic [15:0] mem_rdata;
  logic        mem_en, mem_wr, stall_mem, rdata_valid, err_mem;
  logic [15:0] mem_addr, mem_wdata, rdata_mw;

  int total = 0;
  int bad   = 0;

  dmem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .memread_xm(memread_xm), .memwrite_xm(memwrite_xm),
    .addr_xm(addr_xm), .wdata_xm(wdata_xm),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall_mem(stall_mem), .rdata_mw(rdata_mw), .rdata_valid(rdata_valid),
    .err_mem(err_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          busy;       // cycles mem_busy stays high in ISSUE
    int          done_at;    // WAIT cycle carrying mem_done; 0 = never
    logic [15:0] rdata;
    logic        exp_access;
    logic        exp_err;
    logic        exp_valid;
    logic [15:0] exp_rdata;  // rdata_mw after the transaction
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   nwait;
    v = vecs[idx];
    step();
    memread_xm = v.rd; memwrite_xm = v.wr; addr_xm = v.addr; wdata_xm = v.wdata;
    mem_busy = 1'b0; mem_done = 1'b0;
    #1;
    chk("idle_stall", {15'd0, stall_mem}, {15'd0, v.exp_access});
    chk("idle_en", {15'd0, mem_en}, 16'd0);
    if (!v.exp_access) begin
      step();
      memread_xm = 1'b0; memwrite_xm = 1'b0;
      #1;
      chk("rej_err", {15'd0, err_mem}, {15'd0, v.exp_err});
      chk("rej_en", {15'd0, mem_en}, 16'd0);
      chk("rej_stall", {15'd0, stall_mem}, 16'd0);
      chk("rej_rdata", rdata_mw, v.exp_rdata);
      step();
      #1;
      chk("rej_err_drop", {15'd0, err_mem}, 16'd0);
    end else begin
      for (int k = 0; k <= v.busy; k++) begin
        step();
        memread_xm = 1'b0; memwrite_xm = 1'b0;
        mem_busy = (k < v.busy);
        #1;
        chk("issue_en", {15'd0, mem_en}, 16'd1);
        chk("issue_stall", {15'd0, stall_mem}, 16'd1);
        chk("issue_wr", {15'd0, mem_wr}, {15'd0, v.wr});
        chk("issue_addr", mem_addr, v.addr);
        chk("issue_wdata", mem_wdata, v.wdata);
      end
      nwait = (v.done_at != 0) ? v.done_at : 15;
      for (int w = 1; w <= nwait; w++) begin
        step();
        mem_busy = 1'b0;
        mem_done = (w == v.done_at);
        mem_rdata = (w == v.done_at) ? v.rdata : 16'hFFFF;
        #1;
        chk("wait_en", {15'd0, mem_en}, 16'd0);
        chk("wait_stall", {15'd0, stall_mem}, 16'd1);
        chk("wait_err", {15'd0, err_mem}, 16'd0);
      end
      step();
      mem_done = 1'b0;
      #1;
      chk("done_stall", {15'd0, stall_mem}, 16'd0);
      chk("done_valid", {15'd0, rdata_valid}, {15'd0, v.exp_valid});
      chk("done_err", {15'd0, err_mem}, {15'd0, v.exp_err});
      chk("done_rdata", rdata_mw, v.exp_rdata);
      step();
      #1;
      chk("post_valid", {15'd0, rdata_valid}, 16'd0);
      chk("post_err", {15'd0, err_mem}, 16'd0);
      chk("post_stall", {15'd0, stall_mem}, 16'd0);
      chk("post_rdata", rdata_mw, v.exp_rdata);
    end
    $display("txn %0d rd=%0b wr=%0b addr=%h rdata_mw=%h err_seen=%0b", idx, v.rd, v.wr, v.addr, rdata_mw, v.exp_err);
  endtask

  initial begin
    //               rd wr addr      wdata     bsy dn rdata     acc err val exp_rdata
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0, 2, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 3, 1, 16'h0BAD, 1'b1, 1'b0, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1, 1, 16'h5A5A, 1'b1, 1'b0, 1'b1, 16'h5A5A};
    vecs[3] = '{1'b1, 1'b1, 16'h0040, 16'h9999, 0, 1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5A5A};
    vecs[4] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 0, 0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFE, 16'hABCD, 0, 4, 16'h0BAD, 1'b1, 1'b0, 1'b0, 16'h0000};
`ifdef DMEM_ALIGN_CHK_EN
    vecs[6] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 0, 1, 16'h1357, 1'b0, 1'b1, 1'b0, 16'h0000};
`else
    vecs[6] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 0, 1, 16'h1357, 1'b1, 1'b0, 1'b1, 16'h1357};
`endif
    vecs[7] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 2, 3, 16'hC3C3, 1'b1, 1'b0, 1'b1, 16'hC3C3};

    rst_n = 1'b0;
    memread_xm = 1'b0; memwrite_xm = 1'b0; addr_xm = 16'h0; wdata_xm = 16'h0;
    mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0;
    step(); step();
    #1;
    chk("rst_en", {15'd0, mem_en}, 16'd0);
    chk("rst_stall", {15'd0, stall_mem}, 16'd0);
    chk("rst_rdata", rdata_mw, 16'd0);
    chk("rst_valid", {15'd0, rdata_valid}, 16'd0);
    chk("rst_err", {15'd0, err_mem}, 16'd0);
    chk("rst_addr", mem_addr, 16'd0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Stray mem_done while idle must not touch rdata_mw.
    step();
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_done = 1'b0;
    #1;
    chk("stray_rdata", rdata_mw, 16'hC3C3);
    chk("stray_valid", {15'd0, rdata_valid}, 16'd0);
    chk("stray_stall", {15'd0, stall_mem}, 16'd0);
    $display("seq stray_done rdata_mw=%h", rdata_mw);

    // Request held through DONE: captured only after DONE returns to IDLE.
    step();
    memread_xm = 1'b1; addr_xm = 16'h0200;
    step();                                   // ISSUE
    step();                                   // WAIT
    mem_done = 1'b1; mem_rdata = 16'h2468;
    step();                                   // DONE, request still present
    mem_done = 1'b0; addr_xm = 16'h0444;
    #1;
    chk("hold_done_stall", {15'd0, stall_mem}, 16'd0);
    chk("hold_done_rdata", rdata_mw, 16'h2468);
    step();                                   // IDLE capture cycle
    #1;
    chk("hold_idle_en", {15'd0, mem_en}, 16'd0);
    chk("hold_idle_stall", {15'd0, stall_mem}, 16'd1);
    step();                                   // ISSUE of the second request
    memread_xm = 1'b0;
    #1;
    chk("hold_issue_en", {15'd0, mem_en}, 16'd1);
    chk("hold_issue_addr", mem_addr, 16'h0444);
    $display("seq held_request mem_addr=%h", mem_addr);

    // Reset during WAIT, then a late mem_done after release.
    step();                                   // WAIT
    #1;
    chk("rstw_pre_stall", {15'd0, stall_mem}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_en", {15'd0, mem_en}, 16'd0);
    chk("rstw_stall", {15'd0, stall_mem}, 16'd0);
    chk("rstw_rdata", rdata_mw, 16'd0);
    chk("rstw_valid", {15'd0, rdata_valid}, 16'd0);
    chk("rstw_err", {15'd0, err_mem}, 16'd0);
    chk("rstw_addr", mem_addr, 16'd0);
    step();
    rst_n = 1'b1;
    step();
    mem_done = 1'b1; mem_rdata = 16'h7777;
    step();
    mem_done = 1'b0;
    #1;
    chk("late_rdata", rdata_mw, 16'd0);
    chk("late_valid", {15'd0, rdata_valid}, 16'd0);
    chk("late_en", {15'd0, mem_en}, 16'd0);
    chk("late_stall", {15'd0, stall_mem}, 16'd0);
    $display("seq reset_in_wait rdata_mw=%h", rdata_mw);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
